apb_master_bridge: RTL and testbench

Parametrised APB master that converts a simple valid/ready request port into APB4-style SETUP/ACCESS transfers toward up to NUM_SLAVES slaves. It replaces the single-slave, single-strobe request/response structs with a bridge that has a byte-strobe bus, address-based slave decode with decode-error responses, and an optional wait-state timeout. It sits between an internal requester, such as a NoC endpoint or CPU-side adapter, and the peripheral APB segment.

---
 rtl/apb_pkg.sv | 36 +++
 rtl/apb_timeout_cnt.sv | 45 ++++
 rtl/apb_master_bridge.sv | 171 +++++++++++++++++
 tb/tb_apb_master_bridge.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
//------------------------------------------------------------------------------
// Module  : apb_pkg
// Brief   : APB shared types, default widths and master-bridge FSM states.
// Revision: 1.1
//------------------------------------------------------------------------------
`default_nettype none

package apb_pkg;

  localparam int APB_ADDR_WIDTH = 14;
  localparam int APB_DATA_WIDTH = 32;

  typedef struct packed {
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [APB_DATA_WIDTH-1:0] pwdata;
  } apb_req_s;

  typedef struct packed {
    logic                      pready;
    logic                      pslverr;
    logic [APB_DATA_WIDTH-1:0] prdata;
  } apb_resp_s;

  typedef enum logic [1:0] {
    APB_M_IDLE   = 2'd0,
    APB_M_SETUP  = 2'd1,
    APB_M_ACCESS = 2'd2,
    APB_M_RESP   = 2'd3
  } apb_master_state_e;

endpackage

`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
//------------------------------------------------------------------------------
// Module  : apb_timeout_cnt
// Brief   : ACCESS wait-state counter; used only when APB_TIMEOUT_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module apb_timeout_cnt #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CNT_WIDTH = $clog2(LIMIT + 1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the wait cycle that takes the count to LIMIT.
  assign expired = inc && (cnt_q == CNT_WIDTH'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/apb_master_bridge.sv
//------------------------------------------------------------------------------
// Module  : apb_master_bridge
// Brief   : valid/ready request to multi-slave APB4 master with address decode.
//           Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH      = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH      = APB_DATA_WIDTH,
  parameter int NUM_SLAVES      = 4,
  parameter int SLAVE_ADDR_BITS = 10,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  input  logic [DATA_WIDTH/8-1:0]        req_strb,
  output logic                           rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic [ADDR_WIDTH-1:0]          PADDR,
  output logic [NUM_SLAVES-1:0]          PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [DATA_WIDTH-1:0]          PWDATA,
  output logic [DATA_WIDTH/8-1:0]        PSTRB,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]          PREADY,
  input  logic [NUM_SLAVES-1:0]          PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = ADDR_WIDTH - SLAVE_ADDR_BITS;

  apb_master_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic                  write_q, write_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [IDX_WIDTH-1:0]  req_idx;
  logic                  idx_ok;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  tmo_expired;
  logic                  bus_active;

  assign req_idx = req_addr[ADDR_WIDTH-1:SLAVE_ADDR_BITS];
  assign idx_ok  = (32'(req_idx) < 32'(NUM_SLAVES));

  // Only the addressed slave's response lines are observed.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_WIDTH'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clear   (state_q == APB_M_SETUP),
    .inc     ((state_q == APB_M_ACCESS) && !sel_ready),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    write_d = write_q;
    idx_d   = idx_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      APB_M_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          strb_d  = req_write ? req_strb : '0;
          write_d = req_write;
          idx_d   = req_idx;
          rdata_d = '0;
          err_d   = !idx_ok;
          state_d = idx_ok ? APB_M_SETUP : APB_M_RESP;
        end
      end
      APB_M_SETUP: state_d = APB_M_ACCESS;
      APB_M_ACCESS: begin
        if (sel_ready) begin
          err_d   = sel_err;
          rdata_d = (!write_q && !sel_err) ? sel_rdata : '0;
          state_d = APB_M_RESP;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = APB_M_RESP;
        end
      end
      APB_M_RESP: state_d = APB_M_IDLE;
      default:    state_d = APB_M_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= APB_M_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Select/enable decode straight from state so an async reset drops them at once.
  assign bus_active = (state_q == APB_M_SETUP) || (state_q == APB_M_ACCESS);

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_psel
    assign PSEL[g] = bus_active && (idx_q == IDX_WIDTH'(g));
  end

  assign PENABLE   = (state_q == APB_M_ACCESS);
  assign req_ready = (state_q == APB_M_IDLE);
  assign rsp_valid = (state_q == APB_M_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;
  assign PSTRB     = strb_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
//------------------------------------------------------------------------------
// Module  : tb_apb_master_bridge
// Brief   : Directed self-checking bench for apb_master_bridge (APB_TIMEOUT_EN aware).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_apb_master_bridge;

  logic         PCLK = 1'b0;
  logic         PRESETn;
  logic         req_valid, req_ready, req_write;
  logic [13:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   req_strb;
  logic         rsp_valid, rsp_err;
  logic [31:0]  rsp_rdata;
  logic [13:0]  PADDR;
  logic [3:0]   PSEL;
  logic         PENABLE, PWRITE;
  logic [31:0]  PWDATA;
  logic [3:0]   PSTRB;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY, PSLVERR;

  int vec  = 0;
  int errs = 0;

  apb_master_bridge #(
    .ADDR_WIDTH(14), .DATA_WIDTH(32), .NUM_SLAVES(4),
    .SLAVE_ADDR_BITS(10), .TIMEOUT_CYCLES(8)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic w, input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_strb  = s;
    req_valid = 1'b1;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; PRDATA = '0; PREADY = '0; PSLVERR = '0;
    tick(); tick();
    vec++; if (PSEL !== 4'b0000) begin errs++; $display("FAIL rst_psel: got %b want 0000", PSEL); end
    vec++; if (PENABLE !== 1'b0) begin errs++; $display("FAIL rst_penable: got %b want 0", PENABLE); end
    vec++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errs++; $display("FAIL rst_rsp: got v=%b e=%b want 0/0", rsp_valid, rsp_err); end
    vec++; if (rsp_rdata !== 32'h0 || PWDATA !== 32'h0) begin errs++; $display("FAIL rst_data: got rdata=%h pwdata=%h want 0", rsp_rdata, PWDATA); end
    vec++; if (PADDR !== 14'h0 || PSTRB !== 4'h0 || PWRITE !== 1'b0) begin errs++; $display("FAIL rst_bus: got paddr=%h pstrb=%h pwrite=%b want 0", PADDR, PSTRB, PWRITE); end
    PRESETn = 1'b1;
    tick();
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_write();
    PRDATA = {32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
    PSLVERR = 4'b1101;
    issue(1'b1, 14'h0404, 32'hDEADBEEF, 4'hF);
    vec++; if (req_ready !== 1'b1) begin errs++; $display("FAIL wr_ready_T: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    vec++; if (PSEL !== 4'b0010 || PENABLE !== 1'b0) begin errs++; $display("FAIL wr_setup: got psel=%b en=%b want 0010/0", PSEL, PENABLE); end
    vec++; if (PADDR !== 14'h0404 || PWRITE !== 1'b1) begin errs++; $display("FAIL wr_addr: got %h/%b want 0404/1", PADDR, PWRITE); end
    PREADY = 4'b0010;
    tick();
    vec++; if (PSEL !== 4'b0010 || PENABLE !== 1'b1) begin errs++; $display("FAIL wr_access: got psel=%b en=%b want 0010/1", PSEL, PENABLE); end
    vec++; if (PSTRB !== 4'hF || PWDATA !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_data: got strb=%h data=%h want F/deadbeef", PSTRB, PWDATA); end
    tick();
    vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin errs++; $display("FAIL wr_rsp: got v=%b e=%b d=%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
    vec++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0) begin errs++; $display("FAIL wr_resp_bus: got psel=%b en=%b want 0", PSEL, PENABLE); end
    PREADY = '0; PSLVERR = '0;
    tick();
    vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errs++; $display("FAIL wr_idle: got ready=%b v=%b want 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_read_wait();
    PRDATA = {32'h12345678, 32'hAAAAAAAA, 32'h55555555, 32'h0F0F0F0F};
    issue(1'b0, 14'h0C10, 32'hFFFFFFFF, 4'hF);
    tick();
    req_valid = 1'b0;
    vec++; if (PSEL !== 4'b1000) begin errs++; $display("FAIL rd_setup_psel: got %b want 1000", PSEL); end
    PREADY = 4'b0111;
    tick();
    for (int k = 0; k < 3; k++) begin
      vec++; if (PENABLE !== 1'b1 || PSEL !== 4'b1000 || rsp_valid !== 1'b0) begin errs++; $display("FAIL rd_wait%0d: got en=%b psel=%b v=%b want 1/1000/0", k, PENABLE, PSEL, rsp_valid); end
      vec++; if (PADDR !== 14'h0C10 || PSTRB !== 4'h0 || PWRITE !== 1'b0) begin errs++; $display("FAIL rd_bus%0d: got paddr=%h strb=%h wr=%b want 0c10/0/0", k, PADDR, PSTRB, PWRITE); end
      tick();
    end
    PREADY = 4'b1000;
    vec++; if (PENABLE !== 1'b1 || rsp_valid !== 1'b0) begin errs++; $display("FAIL rd_last_access: got en=%b v=%b want 1/0", PENABLE, rsp_valid); end
    tick();
    vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h12345678) begin errs++; $display("FAIL rd_rsp: got v=%b e=%b d=%h want 1/0/12345678", rsp_valid, rsp_err, rsp_rdata); end
    vec++; if (PADDR !== 14'h0C10) begin errs++; $display("FAIL rd_paddr_hold: got %h want 0c10", PADDR); end
    PREADY = '0;
    tick();
  endtask

  task automatic test_decode_err();
    issue(1'b1, 14'h3000, 32'h11112222, 4'h3);
    tick();
    req_valid = 1'b0;
    vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errs++; $display("FAIL dec_rsp: got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    vec++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || req_ready !== 1'b0) begin errs++; $display("FAIL dec_bus: got psel=%b en=%b rdy=%b want 0/0/0", PSEL, PENABLE, req_ready); end
    tick();
    vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || PSEL !== 4'b0000) begin errs++; $display("FAIL dec_idle: got rdy=%b v=%b psel=%b want 1/0/0", req_ready, rsp_valid, PSEL); end
  endtask

  task automatic test_slave_err();
    PRDATA = {32'h0, 32'h0, 32'h0, 32'h55AA55AA};
    issue(1'b0, 14'h0010, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    vec++; if (PSEL !== 4'b0001) begin errs++; $display("FAIL serr_psel: got %b want 0001", PSEL); end
    PREADY = 4'b0001; PSLVERR = 4'b0001;
    tick();
    tick();
    vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errs++; $display("FAIL serr_rsp: got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    PREADY = '0; PSLVERR = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_rdy, exp_v;
    exp_rdy = 5'b10001;
    exp_v   = 5'b01000;
    PREADY = 4'hF;
    issue(1'b1, 14'h0800, 32'h0BADCAFE, 4'h5);
    for (int c = 0; c < 5; c++) begin
      vec++; if (req_ready !== exp_rdy[c] || rsp_valid !== exp_v[c]) begin errs++; $display("FAIL b2b_T%0d: got rdy=%b v=%b want %b/%b", c, req_ready, rsp_valid, exp_rdy[c], exp_v[c]); end
      tick();
    end
    req_valid = 1'b0;
    vec++; if (PSEL !== 4'b0100 || PSTRB !== 4'h5) begin errs++; $display("FAIL b2b_second: got psel=%b strb=%h want 0100/5", PSEL, PSTRB); end
    tick(); tick(); tick();
    PREADY = '0;
  endtask

  task automatic test_timeout();
    PRDATA = {32'h0, 32'h77778888, 32'h0, 32'h0};
    PREADY = '0;
    issue(1'b0, 14'h0800, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
`ifdef APB_TIMEOUT_EN
    for (int c = 2; c < 10; c++) begin
      tick();
      vec++; if (PENABLE !== 1'b1 || rsp_valid !== 1'b0) begin errs++; $display("FAIL tmo_wait_T%0d: got en=%b v=%b want 1/0", c, PENABLE, rsp_valid); end
    end
    tick();
    vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin errs++; $display("FAIL tmo_rsp: got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_err, rsp_rdata); end
    vec++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0) begin errs++; $display("FAIL tmo_bus: got psel=%b en=%b want 0/0", PSEL, PENABLE); end
    tick();
    // PREADY arriving on the limit cycle completes normally.
    issue(1'b0, 14'h0800, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    for (int c = 2; c < 9; c++) tick();
    tick();
    PREADY = 4'b0100;
    tick();
    vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h77778888) begin errs++; $display("FAIL tmo_race: got v=%b e=%b d=%h want 1/0/77778888", rsp_valid, rsp_err, rsp_rdata); end
    PREADY = '0;
    tick();
`else
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 100; c++) begin
        tick();
        if (rsp_valid === 1'b1) seen++;
      end
      vec++; if (seen !== 0) begin errs++; $display("FAIL notmo_rsp: got %0d responses want 0", seen); end
      vec++; if (PENABLE !== 1'b1 || PSEL !== 4'b0100) begin errs++; $display("FAIL notmo_hold: got en=%b psel=%b want 1/0100", PENABLE, PSEL); end
      PRESETn = 1'b0;
      tick();
      PRESETn = 1'b1;
      tick();
    end
`endif
  endtask

  task automatic test_reset_mid();
    PREADY = '0;
    issue(1'b1, 14'h0C00, 32'h13579BDF, 4'hF);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    vec++; if (PENABLE !== 1'b1 || PSEL !== 4'b1000) begin errs++; $display("FAIL rm_access: got en=%b psel=%b want 1/1000", PENABLE, PSEL); end
    PRESETn = 1'b0;
    #1;
    vec++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0) begin errs++; $display("FAIL rm_async: got psel=%b en=%b want 0/0", PSEL, PENABLE); end
    PREADY = 4'hF;
    tick();
    vec++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rm_norsp0: got %b want 0", rsp_valid); end
    PRESETn = 1'b1;
    tick();
    vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errs++; $display("FAIL rm_norsp1: got v=%b rdy=%b want 0/1", rsp_valid, req_ready); end
    issue(1'b1, 14'h0804, 32'h2468ACE0, 4'hC);
    tick();
    req_valid = 1'b0;
    vec++; if (PSEL !== 4'b0100 || PADDR !== 14'h0804) begin errs++; $display("FAIL rm_new_setup: got psel=%b paddr=%h want 0100/0804", PSEL, PADDR); end
    tick();
    tick();
    vec++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errs++; $display("FAIL rm_new_rsp: got v=%b e=%b want 1/0", rsp_valid, rsp_err); end
    PREADY = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_decode_err();
    test_slave_err();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire
